seq_detect_scheduler: RTL



---
 rtl/seq_detect_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_detect_scheduler.sv
// Run-time programmable serial pattern detector: latches a pattern/length/target via a config
// handshake, then counts overlapping matches over a qualified bit stream until target or abort.
module seq_detect_scheduler #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               a,
    input  logic               a_valid,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   bits_seen_q, bits_seen_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;
    logic               detected_q, detected_d;

    logic               cfg_hs;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   seen_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic [CNT_W-1:0]   count_inc;
    logic               match;

    assign cfg_ready   = (state_q == StIdle) || (state_q == StDone);
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign detected    = detected_q;
    assign match_count = match_count_q;

    always_comb begin
        cfg_hs      = cfg_valid && cfg_ready;
        hist_shift  = {history_q[MAX_LEN-2:0], a};
        seen_inc    = (bits_seen_q < len_q) ? bits_seen_q + 1'b1 : bits_seen_q;
        len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        count_inc   = (&match_count_q) ? match_count_q : match_count_q + 1'b1;
        len_mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        // Compare only the newest len bits; bits_seen guards against stale zeros after entry.
        match = (seen_inc >= len_q) && ((hist_shift & len_mask) == (pattern_q & len_mask));
    end

    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        target_d      = target_q;
        history_d     = history_q;
        bits_seen_d   = bits_seen_q;
        match_count_d = match_count_q;
        detected_d    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (cfg_hs) begin
                    pattern_d = cfg_pattern;
                    len_d     = len_clamped;
                    target_d  = cfg_target;
                    state_d   = StIdle;
                end else if (start && (len_q != '0)) begin
                    history_d     = '0;
                    bits_seen_d   = '0;
                    match_count_d = '0;
                    state_d       = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (a_valid) begin
                    history_d   = hist_shift;
                    bits_seen_d = seen_inc;
                    if (match) begin
                        match_count_d = count_inc;
                        detected_d    = 1'b1;
                        if ((target_q != '0) && (count_inc == target_q)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pattern_q     <= '0;
            len_q         <= '0;
            target_q      <= '0;
            history_q     <= '0;
            bits_seen_q   <= '0;
            match_count_q <= '0;
            detected_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            target_q      <= target_d;
            history_q     <= history_d;
            bits_seen_q   <= bits_seen_d;
            match_count_q <= match_count_d;
            detected_q    <= detected_d;
        end
    end

endmodule
